// File: rtl/ex_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall request.
// Radix-2 shift-add multiply and restoring divide over 32 CALC cycles, then a SIGN fix-up cycle.
module ex_muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        hilo_read,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state, state_nx;
  logic [1:0]  op_q;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc;
  logic [4:0]  cnt;

  logic [31:0] mag_a_in, mag_b_in;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] acc_nx;
  logic [63:0] prod;
  logic [31:0] quot, rem, orig_a;
  logic [31:0] res_hi, res_lo;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: if (cnt == 5'd31) state_nx = SIGN;
      SIGN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Outputs
  always_comb begin
    busy  = (state != IDLE);
    stall = busy & (start | hilo_read | hi_we | lo_we);
  end

  // Operand magnitudes: only signed ops (op[0]) take absolute values
  always_comb begin
    mag_a_in = (op[0] && src_a[31]) ? -src_a : src_a;
    mag_b_in = (op[0] && src_b[31]) ? -src_b : src_b;
  end

  // One iteration step: multiply keeps the multiplier in acc[31:0] and shifts the
  // product in from the top; divide keeps remainder in acc[63:32], quotient grows in acc[31:0]
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    div_trial = acc[63:31] - {1'b0, mag_b};
    if (op_q[1]) begin
      if (div_trial[32]) acc_nx = {acc[62:0], 1'b0};
      else               acc_nx = {div_trial[31:0], acc[30:0], 1'b1};
    end else begin
      acc_nx = {mul_sum, acc[31:1]};
    end
  end

  // Sign correction and result placement
  always_comb begin
    prod   = (op_q[0] && (sign_a ^ sign_b)) ? -acc : acc;
    quot   = (op_q[0] && (sign_a ^ sign_b)) ? -acc[31:0] : acc[31:0];
    rem    = (op_q[0] && sign_a) ? -acc[63:32] : acc[63:32];
    orig_a = (op_q[0] && sign_a) ? -mag_a : mag_a;
    if (!op_q[1]) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (mag_b == '0) begin
      res_hi = orig_a;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              op_q   <= op;
              sign_a <= src_a[31];
              sign_b <= src_b[31];
              mag_a  <= mag_a_in;
              mag_b  <= mag_b_in;
              cnt    <= '0;
              acc    <= op[1] ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
            end
          end
          CALC: begin
            acc <= acc_nx;
            cnt <= cnt + 5'd1;
          end
          SIGN: begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ex_muldiv_sequencer.md
# ex_muldiv_sequencer

Iterative multiply/divide sequencer beside the EX-stage ALU of the five-stage pipeline. It executes MULT, MULTU, DIV and DIVU over 33 cycles, owns the HI/LO registers, and drives a stall request so the pipeline holds any instruction that needs HI/LO or a new mul/div while an operation is in flight. Single-cycle ALU operations in EX proceed in parallel and never stall.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: issue the operation in `op` on the operands `src_a` and `src_b`.
- `op` in 2: operation select. 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `src_a` in 32: rs operand (multiplicand or dividend).
- `src_b` in 32: rt operand (multiplier or divisor).
- `flush` in 1: cancel any in-flight operation.
- `hilo_read` in 1: the instruction in EX is MFHI or MFLO.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO data.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse marking that HI/LO have just been updated.
- `stall` out 1: request to the pipeline to hold IF/ID/EX.

## Operation
- **States:** IDLE, CALC, SIGN.
- **IDLE → CALC:** taken at an edge where `start` = 1 and `flush` = 0.
  - The magnitudes of the operands are latched. Magnitudes are taken only for signed ops.
  - The signs of `src_a` and `src_b` are latched.
  - `op` is latched.
  - The 5-bit iteration counter is cleared to 0.
- **CALC:** one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring step using a 33-bit subtract.
  - The counter increments each step. When the counter reaches 31, the state moves to SIGN.
- **SIGN:** write the corrected result to HI/LO, set `done` = 1, then return to IDLE.
- **Sign rules:**
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ. The remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- **Result placement:**
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- **Divide by zero:** latency is unchanged. Result is LO = 32'hFFFFFFFF and HI = the original `src_a`, regardless of signedness.
- **DIV 32'h80000000 / 32'hFFFFFFFF:** LO = 32'h80000000, HI = 0. No trap.
- **stall** = `busy` & (`start` | `hilo_read` | `hi_we` | `lo_we`). This is combinational.
- **`start` while busy:** ignored. The held instruction re-presents it after completion.
- **MTHI/MTLO:** applied only when the state is IDLE.
  - `start` together with `hi_we`/`lo_we` in IDLE: the write happens at that edge and the operation also begins. Its result later overwrites the write.
- **`flush`:** has priority over everything.
  - The state goes to IDLE at the next edge, and `done` is not pulsed.
  - HI/LO are unchanged. An MT write in the same cycle is suppressed.
  - `start` in the same cycle is not accepted.

## Timing
- **Reset values:** state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, counter = 0. `stall` = 0 follows from `busy` = 0.
- **Latency:** with `start` sampled at edge E0:
  - CALC steps occur at edges E1..E32.
  - SIGN executes at E33.
  - HI/LO and `done` = 1 are visible in the cycle after E33, while `busy` = 0 in that same cycle.
- **Throughput:** the next `start` can be accepted at E33 + 1 at the earliest. `busy` is high from E0 through E33 inclusive, i.e. 33 cycles.
- **`done`:** high exactly one cycle per completed operation. Never high after a flush or reset.
- **Reset mid-operation:** asynchronous return to the reset values. Any partial result is discarded.
- **MT write:** takes effect at the sampling edge; `hi`/`lo` show the new value in the next cycle.

## Test plan
- **MULT / MULTU:** MULT with `src_a` = 32'hFFFFFFFE, `src_b` = 3 → after 33 cycles HI = 32'hFFFFFFFF, LO = 32'hFFFFFFFA, `done` pulses once. The same operands with MULTU → HI = 32'h00000002, LO = 32'hFFFFFFFA.
- **DIV / DIVU:** DIV −7 / 2 → LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF. DIVU 100 / 7 → LO = 32'h0000000E, HI = 32'h00000002. DIV 32'h80000000 / 32'hFFFFFFFF → LO = 32'h80000000, HI = 0.
- **Divide by zero:** DIVU 32'h12345678 / 0 → LO = 32'hFFFFFFFF, HI = 32'h12345678, with the same 33-cycle latency.
- **Stall behaviour:** start a MULT, then:
  - hold `hilo_read` = 1 → `stall` = 1 every busy cycle and 0 in the `done` cycle;
  - with `hilo_read` = 0, a plain ALU op gives `stall` = 0;
  - a second `start` while busy is ignored and the first result is intact.
- **Flush:** assert `flush` 10 cycles after `start` → next cycle `busy` = 0, HI/LO keep their prior values, no `done`. Also: `hi_we` with `wdata` = 32'hCAFEF00D in IDLE → `hi` = 32'hCAFEF00D.
- **Reset:** assert `rst` mid-CALC, without waiting for a clock edge → all outputs go to their reset values immediately. After `rst` is released, a new MULTU 5 × 6 gives LO = 30, HI = 0.
